// File: rtl/mem_port_arbiter_if.sv
// External memory req/ack bus shared by the I-side and D-side of the core.
// The arbiter drives the request fields; the memory answers with a one-cycle ack.
interface mem_port_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // mem_req rises and stays high until the cycle mem_ack is seen; all request
  // fields are stable while mem_req is high; mem_ack may arrive in the first
  // cycle of mem_req and is sampled on the rising clock edge.
  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and load/store,
// one access at a time, and raises mem_stall while any request is unserved.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [31:0]        i_addr,
  output logic [31:0]        i_rdata,
  output logic               i_done,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [3:0]         d_be,
  input  logic [31:0]        d_addr,
  input  logic [31:0]        d_wdata,
  output logic [31:0]        d_rdata,
  output logic               d_done,
  mem_port_arbiter_if.master mem,
  output logic               mem_stall,
  output logic               bus_err,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [3:0]       be_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;

  logic d_pend;
  logic i_pend;
  logic in_acc;
  logic timed_out;
  logic finish;
  logic grant_d;
  logic grant_i;

  assign d_pend    = d_req & ~d_done;
  assign i_pend    = i_req & ~i_done;
  assign in_acc    = (state == D_ACC) || (state == I_ACC);
  assign timed_out = (cnt == CNT_W'(TIMEOUT));
  // An ack in the same cycle as the timeout still counts as a normal completion.
  assign finish    = in_acc & (mem.mem_ack | timed_out);
  assign grant_d   = (state_next == D_ACC) && (state != D_ACC);
  assign grant_i   = (state_next == I_ACC) && (state != I_ACC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // D-side wins ties: the load/store belongs to the older instruction.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_pend)      state_next = D_ACC;
        else if (i_pend) state_next = I_ACC;
      end
      D_ACC: begin
        if (finish) state_next = i_pend ? I_ACC : IDLE;
      end
      I_ACC: begin
        if (finish) state_next = d_pend ? D_ACC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req   = in_acc;
    mem.mem_we    = we_q;
    mem.mem_be    = be_q;
    mem.mem_addr  = addr_q;
    mem.mem_wdata = wdata_q;
    mem_stall     = (i_req & ~i_done) | (d_req & ~d_done);
    fsm_state     = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt     <= '0;
      bus_err <= 1'b0;
      i_rdata <= 32'h0;
      d_rdata <= 32'h0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
    end else begin
      if (grant_d) begin
        we_q    <= d_we;
        be_q    <= d_be;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
      end else if (grant_i) begin
        we_q    <= 1'b0;
        be_q    <= 4'hf;
        addr_q  <= i_addr;
        wdata_q <= 32'h0;
      end

      if (finish || !in_acc) cnt <= '0;
      else                   cnt <= cnt + 1'b1;

      if (finish && !mem.mem_ack) bus_err <= 1'b1;

      if (finish && state == D_ACC) d_rdata <= mem.mem_ack ? mem.mem_rdata : 32'h0;
      if (finish && state == I_ACC) i_rdata <= mem.mem_ack ? mem.mem_rdata : 32'h0;

      // A side whose request was withdrawn mid-access completes on the bus but is not marked done.
      if (finish && state == D_ACC && d_req) d_done <= 1'b1;
      else if (!mem_stall)                   d_done <= 1'b0;

      if (finish && state == I_ACC && i_req) i_done <= 1'b1;
      else if (!mem_stall)                   i_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a behavioural memory answers the bus with a
// programmable wait count; each task checks one scenario against hand-computed values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_stall;
  logic        bus_err;
  logic [1:0]  fsm_state;

  int errors = 0;
  int checks = 0;

  int ack_delay = 0;
  bit no_ack    = 1'b0;
  int wait_cnt  = 0;

  // {we, be, addr, wdata} of every access the memory acknowledged.
  logic [68:0] obs_q[$];
  logic [68:0] exp_q[$];

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem       (bus),
    .mem_stall (mem_stall),
    .bus_err   (bus_err),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00f00000: return 32'h24020001;
      32'h00f00004: return 32'h8c220000;
      32'h00001000: return 32'h12345678;
      default:      return ~a;
    endcase
  endfunction

  // Memory: ack after ack_delay wait cycles of mem_req, decided mid-cycle so a
  // zero-wait ack lands in the first mem_req cycle.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        if (!no_ack && wait_cnt >= ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          obs_q.push_back({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata});
          wait_cnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  task automatic run_step(input int budget, output int stall_n, output int req_n);
    stall_n = 0;
    req_n   = 0;
    while (mem_stall === 1'b1 && stall_n < budget) begin
      stall_n++;
      if (bus.mem_req === 1'b1) req_n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_access(input string name);
    logic [68:0] got;
    logic [68:0] want;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed %0d accesses, expected %0d", name, obs_q.size(), exp_q.size());
    end else begin
      got  = obs_q.pop_front();
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, got, want);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
    checks++; if ({i_done, d_done, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {i_done, d_done, bus_err}); end
    checks++; if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 69'h0) begin errors++; $display("FAIL reset_bus_fields: got %h expected 0", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}); end
    checks++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata}); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (fsm_state !== 2'd0 || mem_stall !== 1'b0) begin errors++; $display("FAIL reset_idle: state %0d stall %b expected 0 0", fsm_state, mem_stall); end
  endtask

  task automatic test_single_fetch();
    int sn, rn;
    ack_delay = 0;
    i_req = 1'b1; i_addr = 32'h00f00000;
    exp_q.push_back({1'b0, 4'hf, 32'h00f00000, 32'h0});
    #1;
    run_step(20, sn, rn);
    checks++; if (sn != 2) begin errors++; $display("FAIL fetch_stall_cycles: got %0d expected 2", sn); end
    checks++; if (i_done !== 1'b1 || d_done !== 1'b0) begin errors++; $display("FAIL fetch_done: got i=%b d=%b expected i=1 d=0", i_done, d_done); end
    checks++; if (i_rdata !== 32'h24020001) begin errors++; $display("FAIL fetch_rdata: got %h expected 24020001", i_rdata); end
    check_access("fetch_bus_access");
    i_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (i_done !== 1'b0) begin errors++; $display("FAIL fetch_done_clear: got %b expected 0", i_done); end
    checks++; if (i_rdata !== 32'h24020001) begin errors++; $display("FAIL fetch_rdata_hold: got %h expected 24020001", i_rdata); end
  endtask

  task automatic test_back_to_back();
    int sn, rn;
    ack_delay = 0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hf; d_addr = 32'h00001000; d_wdata = 32'h0;
    i_req = 1'b1; i_addr = 32'h00f00004;
    exp_q.push_back({1'b0, 4'hf, 32'h00001000, 32'h0});
    exp_q.push_back({1'b0, 4'hf, 32'h00f00004, 32'h0});
    #1;
    run_step(20, sn, rn);
    checks++; if (sn != 3) begin errors++; $display("FAIL b2b_stall_cycles: got %0d expected 3", sn); end
    checks++; if (rn != 2) begin errors++; $display("FAIL b2b_req_cycles: got %0d expected 2", rn); end
    checks++; if ({i_done, d_done} !== 2'b11) begin errors++; $display("FAIL b2b_done: got %b expected 11", {i_done, d_done}); end
    checks++; if (d_rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_d_rdata: got %h expected 12345678", d_rdata); end
    checks++; if (i_rdata !== 32'h8c220000) begin errors++; $display("FAIL b2b_i_rdata: got %h expected 8c220000", i_rdata); end
    check_access("b2b_first_is_d");
    check_access("b2b_second_is_i");
    idle_inputs();
    @(posedge clk); #1;
    checks++; if ({i_done, d_done} !== 2'b00) begin errors++; $display("FAIL b2b_done_clear: got %b expected 00", {i_done, d_done}); end
  endtask

  task automatic test_store_wait();
    int sn, rn;
    ack_delay = 5;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20000010; d_wdata = 32'hdeadbeef;
    exp_q.push_back({1'b1, 4'b0011, 32'h20000010, 32'hdeadbeef});
    @(posedge clk); #1;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'b0011) begin errors++; $display("FAIL store_bus_fields: got req=%b we=%b be=%b expected 1 1 0011", bus.mem_req, bus.mem_we, bus.mem_be); end
    checks++; if (fsm_state !== 2'd1) begin errors++; $display("FAIL store_state: got %0d expected 1", fsm_state); end
    run_step(40, sn, rn);
    checks++; if (sn + 1 != 7) begin errors++; $display("FAIL store_stall_cycles: got %0d expected 7", sn + 1); end
    checks++; if (rn != 6) begin errors++; $display("FAIL store_req_cycles: got %0d expected 6", rn); end
    checks++; if (d_done !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL store_complete: got done=%b req=%b expected 1 0", d_done, bus.mem_req); end
    check_access("store_bus_access");
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int sn, rn;
    no_ack = 1'b1;
    i_req = 1'b1; i_addr = 32'h00f00008;
    #1;
    run_step(400, sn, rn);
    checks++; if (sn != 257) begin errors++; $display("FAIL timeout_stall_cycles: got %0d expected 257", sn); end
    checks++; if (rn != 256) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 256", rn); end
    checks++; if (bus_err !== 1'b1 || i_done !== 1'b1) begin errors++; $display("FAIL timeout_flags: got err=%b done=%b expected 1 1", bus_err, i_done); end
    checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rdata: got %h expected 0", i_rdata); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL timeout_no_ack: got %0d accesses expected 0", obs_q.size()); end
    idle_inputs();
    @(posedge clk); #1;
    no_ack = 1'b0; ack_delay = 0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hf; d_addr = 32'h00001000;
    exp_q.push_back({1'b0, 4'hf, 32'h00001000, 32'h0});
    #1;
    run_step(20, sn, rn);
    checks++; if (sn != 2) begin errors++; $display("FAIL after_err_stall: got %0d expected 2", sn); end
    checks++; if (d_rdata !== 32'h12345678 || bus_err !== 1'b1) begin errors++; $display("FAIL after_err_access: got rdata=%h err=%b expected 12345678 1", d_rdata, bus_err); end
    check_access("after_err_bus_access");
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    ack_delay = 10;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hf; d_addr = 32'h00003000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (fsm_state !== 2'd1 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got state=%0d req=%b expected 1 1", fsm_state, bus.mem_req); end
    reset = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || fsm_state !== 2'd0) begin errors++; $display("FAIL rst_mid_drop: got req=%b state=%0d expected 0 0", bus.mem_req, fsm_state); end
    checks++; if ({i_done, d_done, bus_err} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 000", {i_done, d_done, bus_err}); end
    checks++; if ({bus.mem_addr, d_rdata, i_rdata} !== 96'h0) begin errors++; $display("FAIL rst_mid_regs: got %h expected 0", {bus.mem_addr, d_rdata, i_rdata}); end
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (obs_q.size() != 0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_abandon: got %0d accesses req=%b expected 0 0", obs_q.size(), bus.mem_req); end
  endtask

  task automatic test_drop_mid_access();
    int rn;
    ack_delay = 3;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hf; d_addr = 32'h00004000;
    exp_q.push_back({1'b0, 4'hf, 32'h00004000, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_req = 1'b0;
    #1;
    checks++; if (mem_stall !== 1'b0 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL drop_stall: got stall=%b req=%b expected 0 1", mem_stall, bus.mem_req); end
    rn = 0;
    while (bus.mem_req === 1'b1 && rn < 20) begin
      rn++;
      @(posedge clk); #1;
    end
    checks++; if (rn != 3) begin errors++; $display("FAIL drop_req_held: got %0d more cycles expected 3", rn); end
    checks++; if (d_done !== 1'b0 || fsm_state !== 2'd0) begin errors++; $display("FAIL drop_no_done: got done=%b state=%0d expected 0 0", d_done, fsm_state); end
    check_access("drop_bus_access");
    ack_delay = 0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_store_wait();
    test_timeout();
    test_reset_mid_access();
    test_drop_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
